// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared AES widths, FSM encoding and byte-select helper
// Revision: 1.0
// ============================================================================
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTE_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

   // Byte 0 is the most significant byte of the state.
   function automatic logic [AES_BYTE_W-1:0] state_byte(input logic [AES_STATE_W-1:0] s,
                                                         input int                     idx);
      return s[AES_STATE_W-1-idx*AES_BYTE_W -: AES_BYTE_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
// inv_sbox : combinational AES inverse S-box lookup
// Revision: 1.0
// ============================================================================
module inv_sbox
   import aes_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] din,
   output logic [AES_BYTE_W-1:0] dout
);

   always_comb begin
      dout = 8'h00;
      case (din)
         8'h00: dout = 8'h52; 8'h01: dout = 8'h09; 8'h02: dout = 8'h6a; 8'h03: dout = 8'hd5; 8'h04: dout = 8'h30; 8'h05: dout = 8'h36; 8'h06: dout = 8'ha5; 8'h07: dout = 8'h38;
         8'h08: dout = 8'hbf; 8'h09: dout = 8'h40; 8'h0a: dout = 8'ha3; 8'h0b: dout = 8'h9e; 8'h0c: dout = 8'h81; 8'h0d: dout = 8'hf3; 8'h0e: dout = 8'hd7; 8'h0f: dout = 8'hfb;
         8'h10: dout = 8'h7c; 8'h11: dout = 8'he3; 8'h12: dout = 8'h39; 8'h13: dout = 8'h82; 8'h14: dout = 8'h9b; 8'h15: dout = 8'h2f; 8'h16: dout = 8'hff; 8'h17: dout = 8'h87;
         8'h18: dout = 8'h34; 8'h19: dout = 8'h8e; 8'h1a: dout = 8'h43; 8'h1b: dout = 8'h44; 8'h1c: dout = 8'hc4; 8'h1d: dout = 8'hde; 8'h1e: dout = 8'he9; 8'h1f: dout = 8'hcb;
         8'h20: dout = 8'h54; 8'h21: dout = 8'h7b; 8'h22: dout = 8'h94; 8'h23: dout = 8'h32; 8'h24: dout = 8'ha6; 8'h25: dout = 8'hc2; 8'h26: dout = 8'h23; 8'h27: dout = 8'h3d;
         8'h28: dout = 8'hee; 8'h29: dout = 8'h4c; 8'h2a: dout = 8'h95; 8'h2b: dout = 8'h0b; 8'h2c: dout = 8'h42; 8'h2d: dout = 8'hfa; 8'h2e: dout = 8'hc3; 8'h2f: dout = 8'h4e;
         8'h30: dout = 8'h08; 8'h31: dout = 8'h2e; 8'h32: dout = 8'ha1; 8'h33: dout = 8'h66; 8'h34: dout = 8'h28; 8'h35: dout = 8'hd9; 8'h36: dout = 8'h24; 8'h37: dout = 8'hb2;
         8'h38: dout = 8'h76; 8'h39: dout = 8'h5b; 8'h3a: dout = 8'ha2; 8'h3b: dout = 8'h49; 8'h3c: dout = 8'h6d; 8'h3d: dout = 8'h8b; 8'h3e: dout = 8'hd1; 8'h3f: dout = 8'h25;
         8'h40: dout = 8'h72; 8'h41: dout = 8'hf8; 8'h42: dout = 8'hf6; 8'h43: dout = 8'h64; 8'h44: dout = 8'h86; 8'h45: dout = 8'h68; 8'h46: dout = 8'h98; 8'h47: dout = 8'h16;
         8'h48: dout = 8'hd4; 8'h49: dout = 8'ha4; 8'h4a: dout = 8'h5c; 8'h4b: dout = 8'hcc; 8'h4c: dout = 8'h5d; 8'h4d: dout = 8'h65; 8'h4e: dout = 8'hb6; 8'h4f: dout = 8'h92;
         8'h50: dout = 8'h6c; 8'h51: dout = 8'h70; 8'h52: dout = 8'h48; 8'h53: dout = 8'h50; 8'h54: dout = 8'hfd; 8'h55: dout = 8'hed; 8'h56: dout = 8'hb9; 8'h57: dout = 8'hda;
         8'h58: dout = 8'h5e; 8'h59: dout = 8'h15; 8'h5a: dout = 8'h46; 8'h5b: dout = 8'h57; 8'h5c: dout = 8'ha7; 8'h5d: dout = 8'h8d; 8'h5e: dout = 8'h9d; 8'h5f: dout = 8'h84;
         8'h60: dout = 8'h90; 8'h61: dout = 8'hd8; 8'h62: dout = 8'hab; 8'h63: dout = 8'h00; 8'h64: dout = 8'h8c; 8'h65: dout = 8'hbc; 8'h66: dout = 8'hd3; 8'h67: dout = 8'h0a;
         8'h68: dout = 8'hf7; 8'h69: dout = 8'he4; 8'h6a: dout = 8'h58; 8'h6b: dout = 8'h05; 8'h6c: dout = 8'hb8; 8'h6d: dout = 8'hb3; 8'h6e: dout = 8'h45; 8'h6f: dout = 8'h06;
         8'h70: dout = 8'hd0; 8'h71: dout = 8'h2c; 8'h72: dout = 8'h1e; 8'h73: dout = 8'h8f; 8'h74: dout = 8'hca; 8'h75: dout = 8'h3f; 8'h76: dout = 8'h0f; 8'h77: dout = 8'h02;
         8'h78: dout = 8'hc1; 8'h79: dout = 8'haf; 8'h7a: dout = 8'hbd; 8'h7b: dout = 8'h03; 8'h7c: dout = 8'h01; 8'h7d: dout = 8'h13; 8'h7e: dout = 8'h8a; 8'h7f: dout = 8'h6b;
         8'h80: dout = 8'h3a; 8'h81: dout = 8'h91; 8'h82: dout = 8'h11; 8'h83: dout = 8'h41; 8'h84: dout = 8'h4f; 8'h85: dout = 8'h67; 8'h86: dout = 8'hdc; 8'h87: dout = 8'hea;
         8'h88: dout = 8'h97; 8'h89: dout = 8'hf2; 8'h8a: dout = 8'hcf; 8'h8b: dout = 8'hce; 8'h8c: dout = 8'hf0; 8'h8d: dout = 8'hb4; 8'h8e: dout = 8'he6; 8'h8f: dout = 8'h73;
         8'h90: dout = 8'h96; 8'h91: dout = 8'hac; 8'h92: dout = 8'h74; 8'h93: dout = 8'h22; 8'h94: dout = 8'he7; 8'h95: dout = 8'had; 8'h96: dout = 8'h35; 8'h97: dout = 8'h85;
         8'h98: dout = 8'he2; 8'h99: dout = 8'hf9; 8'h9a: dout = 8'h37; 8'h9b: dout = 8'he8; 8'h9c: dout = 8'h1c; 8'h9d: dout = 8'h75; 8'h9e: dout = 8'hdf; 8'h9f: dout = 8'h6e;
         8'ha0: dout = 8'h47; 8'ha1: dout = 8'hf1; 8'ha2: dout = 8'h1a; 8'ha3: dout = 8'h71; 8'ha4: dout = 8'h1d; 8'ha5: dout = 8'h29; 8'ha6: dout = 8'hc5; 8'ha7: dout = 8'h89;
         8'ha8: dout = 8'h6f; 8'ha9: dout = 8'hb7; 8'haa: dout = 8'h62; 8'hab: dout = 8'h0e; 8'hac: dout = 8'haa; 8'had: dout = 8'h18; 8'hae: dout = 8'hbe; 8'haf: dout = 8'h1b;
         8'hb0: dout = 8'hfc; 8'hb1: dout = 8'h56; 8'hb2: dout = 8'h3e; 8'hb3: dout = 8'h4b; 8'hb4: dout = 8'hc6; 8'hb5: dout = 8'hd2; 8'hb6: dout = 8'h79; 8'hb7: dout = 8'h20;
         8'hb8: dout = 8'h9a; 8'hb9: dout = 8'hdb; 8'hba: dout = 8'hc0; 8'hbb: dout = 8'hfe; 8'hbc: dout = 8'h78; 8'hbd: dout = 8'hcd; 8'hbe: dout = 8'h5a; 8'hbf: dout = 8'hf4;
         8'hc0: dout = 8'h1f; 8'hc1: dout = 8'hdd; 8'hc2: dout = 8'ha8; 8'hc3: dout = 8'h33; 8'hc4: dout = 8'h88; 8'hc5: dout = 8'h07; 8'hc6: dout = 8'hc7; 8'hc7: dout = 8'h31;
         8'hc8: dout = 8'hb1; 8'hc9: dout = 8'h12; 8'hca: dout = 8'h10; 8'hcb: dout = 8'h59; 8'hcc: dout = 8'h27; 8'hcd: dout = 8'h80; 8'hce: dout = 8'hec; 8'hcf: dout = 8'h5f;
         8'hd0: dout = 8'h60; 8'hd1: dout = 8'h51; 8'hd2: dout = 8'h7f; 8'hd3: dout = 8'ha9; 8'hd4: dout = 8'h19; 8'hd5: dout = 8'hb5; 8'hd6: dout = 8'h4a; 8'hd7: dout = 8'h0d;
         8'hd8: dout = 8'h2d; 8'hd9: dout = 8'he5; 8'hda: dout = 8'h7a; 8'hdb: dout = 8'h9f; 8'hdc: dout = 8'h93; 8'hdd: dout = 8'hc9; 8'hde: dout = 8'h9c; 8'hdf: dout = 8'hef;
         8'he0: dout = 8'ha0; 8'he1: dout = 8'he0; 8'he2: dout = 8'h3b; 8'he3: dout = 8'h4d; 8'he4: dout = 8'hae; 8'he5: dout = 8'h2a; 8'he6: dout = 8'hf5; 8'he7: dout = 8'hb0;
         8'he8: dout = 8'hc8; 8'he9: dout = 8'heb; 8'hea: dout = 8'hbb; 8'heb: dout = 8'h3c; 8'hec: dout = 8'h83; 8'hed: dout = 8'h53; 8'hee: dout = 8'h99; 8'hef: dout = 8'h61;
         8'hf0: dout = 8'h17; 8'hf1: dout = 8'h2b; 8'hf2: dout = 8'h04; 8'hf3: dout = 8'h7e; 8'hf4: dout = 8'hba; 8'hf5: dout = 8'h77; 8'hf6: dout = 8'hd6; 8'hf7: dout = 8'h26;
         8'hf8: dout = 8'he1; 8'hf9: dout = 8'h69; 8'hfa: dout = 8'h14; 8'hfb: dout = 8'h63; 8'hfc: dout = 8'h55; 8'hfd: dout = 8'h21; 8'hfe: dout = 8'h0c; 8'hff: dout = 8'h7d;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/inv_subbytes_iter.sv
`default_nettype none
// ============================================================================
// inv_subbytes_iter : iterative AES InvSubBytes, LANES bytes substituted per clock
// Revision: 1.0
// ============================================================================
module inv_subbytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [AES_STATE_W-1:0] in_state,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam int NCHUNK = 16 / LANES;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NCHUNK - 1);

   fsm_state_t             r_state;
   fsm_state_t             w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [AES_STATE_W-1:0] r_work;
   logic [AES_STATE_W-1:0] w_work_nxt;
   logic [AES_BYTE_W-1:0]  w_lane_in  [LANES];
   logic [AES_BYTE_W-1:0]  w_lane_out [LANES];
   int                     w_base;

   // Index of the first byte of the chunk currently being substituted.
   assign w_base = int'(r_cnt) * LANES;

   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         assign w_lane_in[g] = state_byte(r_work, w_base + g);
         inv_sbox u_inv_sbox (
            .din  (w_lane_in[g]),
            .dout (w_lane_out[g])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_work  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_work  <= w_work_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_work_nxt  = r_work;
      in_ready    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_work_nxt  = in_state;
               w_cnt_nxt   = '0;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            for (int k = 0; k < LANES; k++) begin
               w_work_nxt[AES_STATE_W-1-(w_base+k)*AES_BYTE_W -: AES_BYTE_W] = w_lane_out[k];
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == c_last_cnt) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            // A consumer handoff frees the work register for a new load in the same edge.
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  w_work_nxt  = in_state;
                  w_cnt_nxt   = '0;
                  w_state_nxt = BUSY;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign out_state = r_work;
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_inv_subbytes_iter.sv
`default_nettype none
// ============================================================================
// tb_inv_subbytes_iter : directed self-checking bench for LANES = 4 and 16
// Revision: 1.0
// ============================================================================
module tb_inv_subbytes_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_state;
   logic         in_valid4, in_valid16, out_ready;
   logic         in_ready4, in_ready16, out_valid4, out_valid16, busy4, busy16;
   logic [127:0] out_state4, out_state16;
   logic [7:0]   fwd [256];
   int           n_checks = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   inv_subbytes_iter #(.LANES(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_state  (in_state),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .out_state (out_state4),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .busy      (busy4)
   );

   inv_subbytes_iter #(.LANES(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_state  (in_state),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .out_state (out_state16),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .busy      (busy16)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Forward S-box built from GF(2^8) inversion plus the affine map.
   task automatic build_fwd();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         fwd[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   // Called one time unit after a rising edge; returns one time unit after the accepting edge.
   task automatic accept(input bit wide, input logic [127:0] din, output bit got);
      int tries = 0;
      in_state = din;
      if (wide) in_valid16 = 1'b1; else in_valid4 = 1'b1;
      got = 1'b0;
      while (!got && tries < 40) begin
         #1;
         got = wide ? in_ready16 : in_ready4;
         @(posedge clk); #1;
         tries++;
      end
      in_valid4  = 1'b0;
      in_valid16 = 1'b0;
      in_state   = ~din;
   endtask

   task automatic wait_valid(input bit wide, output int edges);
      edges = 0;
      while (!(wide ? out_valid16 : out_valid4) && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_held_out_valid: got %b want 0", out_valid4); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid4); end
      n_checks++; if (out_state4 !== 128'h0) begin n_fail++; $display("FAIL reset_out_state: got %h want 0", out_state4); end
      n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready4); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy4); end
      n_checks++; if ({out_valid16, in_ready16, busy16} !== 3'b010) begin n_fail++; $display("FAIL reset_l16_flags: got %b want 010", {out_valid16, in_ready16, busy16}); end
   endtask

   task automatic test_single();
      bit got;
      int edges;
      accept(1'b0, 128'h0, got);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", got); end
      n_checks++; if ({busy4, in_ready4, out_valid4} !== 3'b100) begin n_fail++; $display("FAIL single_busy_flags: got %b want 100", {busy4, in_ready4, out_valid4}); end
      wait_valid(1'b0, edges);
      n_checks++; if (edges != 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", edges); end
      n_checks++; if (out_state4 !== {16{8'h52}}) begin n_fail++; $display("FAIL single_out_state: got %h want %h", out_state4, {16{8'h52}}); end
      @(posedge clk); #1;
      n_checks++; if ({out_valid4, in_ready4} !== 2'b01) begin n_fail++; $display("FAIL single_drain: got %b want 01", {out_valid4, in_ready4}); end
   endtask

   task automatic test_mixed();
      bit got;
      int edges;
      logic [127:0] din = 128'h6316ED52_006316ED_52006316_ED520063;
      logic [127:0] exp = 128'h00FF5348_5200FF53_485200FF_53485200;
      accept(1'b0, din, got);
      wait_valid(1'b0, edges);
      n_checks++; if (!got || edges != 4) begin n_fail++; $display("FAIL mixed_l4_latency: got accept=%b edges=%0d want 1/4", got, edges); end
      n_checks++; if (out_state4 !== exp) begin n_fail++; $display("FAIL mixed_l4_out_state: got %h want %h", out_state4, exp); end
      @(posedge clk); #1;
      accept(1'b1, din, got);
      wait_valid(1'b1, edges);
      n_checks++; if (!got || edges != 1) begin n_fail++; $display("FAIL mixed_l16_latency: got accept=%b edges=%0d want 1/1", got, edges); end
      n_checks++; if (out_state16 !== exp) begin n_fail++; $display("FAIL mixed_l16_out_state: got %h want %h", out_state16, exp); end
      @(posedge clk); #1;
      n_checks++; if ({out_valid16, in_ready16} !== 2'b01) begin n_fail++; $display("FAIL mixed_l16_drain: got %b want 01", {out_valid16, in_ready16}); end
   endtask

   task automatic test_back_to_back();
      bit got;
      int edges;
      out_ready = 1'b0;
      accept(1'b0, {16{8'h52}}, got);
      wait_valid(1'b0, edges);
      n_checks++; if (!got || edges != 4) begin n_fail++; $display("FAIL bp_latency: got accept=%b edges=%0d want 1/4", got, edges); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid4, in_ready4, out_state4} !== {1'b1, 1'b0, {16{8'h48}}}) begin
            n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b r=%b %h want v=1 r=0 %h", c, out_valid4, in_ready4, out_state4, {16{8'h48}});
         end
      end
      out_ready = 1'b1;
      accept(1'b0, {16{8'hED}}, got);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_in_done: got %b want 1", got); end
      n_checks++; if ({out_valid4, busy4} !== 2'b01) begin n_fail++; $display("FAIL b2b_handoff: got %b want 01", {out_valid4, busy4}); end
      wait_valid(1'b0, edges);
      n_checks++; if (edges != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", edges); end
      n_checks++; if (out_state4 !== {16{8'h53}}) begin n_fail++; $display("FAIL b2b_out_state: got %h want %h", out_state4, {16{8'h53}}); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit got;
      bit seen = 1'b0;
      int edges;
      accept(1'b0, 128'h0, got);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({out_valid4, busy4, in_ready4} !== 3'b001) begin n_fail++; $display("FAIL midrst_flags: got %b want 001", {out_valid4, busy4, in_ready4}); end
      n_checks++; if (out_state4 !== 128'h0) begin n_fail++; $display("FAIL midrst_out_state: got %h want 0", out_state4); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid4) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_valid: got %b want 0", seen); end
      accept(1'b0, {16{8'h16}}, got);
      wait_valid(1'b0, edges);
      n_checks++; if (!got || edges != 4) begin n_fail++; $display("FAIL midrst_fresh_latency: got accept=%b edges=%0d want 1/4", got, edges); end
      n_checks++; if (out_state4 !== {16{8'hFF}}) begin n_fail++; $display("FAIL midrst_fresh_state: got %h want %h", out_state4, {16{8'hFF}}); end
      @(posedge clk); #1;
   endtask

   task automatic test_round_trip();
      bit got;
      int edges;
      logic [127:0] orig, sub;
      for (int n = 0; n < 64; n++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         for (int b = 0; b < 16; b++) sub[127-8*b -: 8] = fwd[orig[127-8*b -: 8]];
         accept(1'b0, sub, got);
         wait_valid(1'b0, edges);
         n_checks++;
         if (!got || edges != 4 || out_state4 !== orig) begin
            n_fail++; $display("FAIL round_trip %0d: got %h (edges %0d) want %h", n, out_state4, edges, orig);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      in_state   = 128'h0;
      in_valid4  = 1'b0;
      in_valid16 = 1'b0;
      out_ready  = 1'b1;
      build_fwd();
      test_reset();
      test_single();
      test_mixed();
      test_back_to_back();
      test_reset_mid();
      test_round_trip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
